// File: rtl/decoder_3to8_hs_pkg.sv
// rtl/decoder_3to8_hs_pkg.sv - shared types and helpers for the handshaked 3-to-8 decoder
// Contents: output-width derivation, idle-word constant, buffer occupancy encodings.
package decoder_pkg;

  // Widest one-hot word the idle helper can describe.
  localparam int MAX_N_OUT = 256;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic int n_out(input int w_in);
    return 1 << w_in;
  endfunction

  // Idle word is all zeros, or all ones for an active-low output bus.
  function automatic logic [MAX_N_OUT-1:0] idle_word(input bit active_low);
    return active_low ? {MAX_N_OUT{1'b1}} : {MAX_N_OUT{1'b0}};
  endfunction

endpackage

// File: rtl/decoder_3to8_hs_if.sv
// rtl/decoder_3to8_hs_if.sv - upstream/downstream handshake bundle of the decoder
// Signals: in_valid/in_ready/in_code/in_en (upstream word), out_valid/out_ready/out_y/out_zero
// (downstream word), xfer_cnt (completed output handshakes).
// Modports: slave = decoder side, master = the environment driving it.
interface decoder_3to8_hs_if
  import decoder_pkg::*;
#(
  parameter int W_IN  = 3,
  parameter int CNT_W = 16
) ();

  localparam int N_OUT = n_out(W_IN);

  logic             in_valid;
  logic             in_ready;
  logic [W_IN-1:0]  in_code;
  logic             in_en;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_y;
  logic             out_zero;
  logic [CNT_W-1:0] xfer_cnt;

  modport slave (
    input  in_valid, in_code, in_en, out_ready,
    output in_ready, out_valid, out_y, out_zero, xfer_cnt
  );

  modport master (
    output in_valid, in_code, in_en, out_ready,
    input  in_ready, out_valid, out_y, out_zero, xfer_cnt
  );

endinterface

// File: rtl/decoder_3to8_hs_fifo2.sv
// rtl/decoder_3to8_hs_fifo2.sv - two-entry synchronous FIFO with valid/ready on both ends
// Ports: clk, rst (sync, active-high), in_valid/in_ready/in_data (write side),
// out_valid/out_ready/out_data (read side, out_data is the registered head entry).
module fifo2_sync
  import decoder_pkg::*;
#(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  occ_e          state;
  logic [DW-1:0] head;
  logic [DW-1:0] tail;
  logic          push;
  logic          pop;

  // Ready depends only on the occupancy register and rst, so nothing from
  // out_ready can ripple back upstream in the same cycle.
  assign in_ready  = !rst && (state != OCC_FULL);
  assign out_valid = (state != OCC_EMPTY);
  assign out_data  = head;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OCC_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (push) begin
            head  <= in_data;
            state <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            // Head leaves as the new word arrives: new word goes straight to head.
            head <= in_data;
          end else if (push) begin
            tail  <= in_data;
            state <= OCC_FULL;
          end else if (pop) begin
            state <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            head  <= tail;
            state <= OCC_ONE;
          end
        end
        default: state <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/decoder_3to8_hs.sv
// rtl/decoder_3to8_hs.sv - registered 3-to-8 one-hot decoder with valid/ready on both sides
// Ports: clk, rst (sync, active-high), bus (decoder_3to8_hs_if.slave: input word
// in_code/in_en, output word out_y/out_zero, both handshaked; xfer_cnt pop counter).
// Parameters: W_IN code width, ACTIVE_LOW inverts out_y including idle, CNT_W counter width.
module decoder_3to8_hs
  import decoder_pkg::*;
#(
  parameter int W_IN       = 3,
  parameter int ACTIVE_LOW = 0,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  decoder_3to8_hs_if.slave    bus
);

  localparam int                     N_OUT     = n_out(W_IN);
  localparam logic [MAX_N_OUT-1:0]   IDLE_FULL = idle_word(ACTIVE_LOW != 0);
  localparam logic [N_OUT-1:0]       IDLE_Y    = IDLE_FULL[N_OUT-1:0];

  logic [N_OUT-1:0] dec_word;
  logic [N_OUT:0]   fifo_in;
  logic [N_OUT:0]   fifo_head;
  logic             fifo_valid;
  logic [N_OUT-1:0] head_word;
  logic [CNT_W-1:0] cnt;

  // Decode at acceptance; the buffer holds true-polarity words plus the zero flag.
  always_comb begin
    dec_word = '0;
    if (bus.in_en) begin
      dec_word[bus.in_code] = 1'b1;
    end
  end

  assign fifo_in = {!bus.in_en, dec_word};

  fifo2_sync #(
    .DW (N_OUT + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (fifo_in),
    .out_valid (fifo_valid),
    .out_ready (bus.out_ready),
    .out_data  (fifo_head)
  );

  assign head_word = (ACTIVE_LOW != 0) ? ~fifo_head[N_OUT-1:0] : fifo_head[N_OUT-1:0];

  // Output mux selects on registered occupancy only.
  assign bus.out_valid = fifo_valid;
  assign bus.out_y     = fifo_valid ? head_word : IDLE_Y;
  assign bus.out_zero  = fifo_valid && fifo_head[N_OUT];
  assign bus.xfer_cnt  = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (fifo_valid && bus.out_ready) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/decoder_3to8_hs.md
# decoder_3to8_hs

Registered 3-to-8 one-hot decoder with valid/ready handshakes on both sides. It is the receive-side counterpart of the team's 8:3 encoder: it turns a 3-bit line index back into a one-hot line vector. An `in_en`=0 word decodes to "no line asserted". A 2-entry output buffer absorbs downstream backpressure without dropping codes. A wrapping transfer counter supports bring-up and link checking.

## Interface
- `W_IN`, 3, code width; output width N_OUT = 2**W_IN (8).
- `ACTIVE_LOW`, 0, when 1 every `out_y` bit is inverted, including the idle value.
- `CNT_W`, 16, width of `xfer_cnt`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream word present.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_code`  in  W_IN  line index to decode.
- `in_en`  in  1  1 = decode `in_code`; 0 = emit the all-lines-off word.
- `out_valid`  out  1  head word present.
- `out_ready`  in  1  downstream takes head word.
- `out_y`  out  N_OUT  one-hot decoded word (polarity per `ACTIVE_LOW`).
- `out_zero`  out  1  head word came from `in_en`=0.
- `xfer_cnt`  out  CNT_W  count of completed output handshakes.

## Operation
- Decode at acceptance: word = `in_en` ? (1 << `in_code`) : 0. The word is stored with a zero flag. `ACTIVE_LOW` inversion is applied at the output only.
- Input handshake: push when `in_valid` && `in_ready`. `in_ready` = !rst && (occupancy < 2).
- Output handshake: pop when `out_valid` && `out_ready`. `out_valid` = (occupancy > 0).
- Buffer states are EMPTY(0), ONE(1) and FULL(2):
  - EMPTY, push → ONE.
  - ONE, push only → FULL.
  - ONE, pop only → EMPTY.
  - ONE, push and pop → ONE. The new word becomes head on the next cycle, and order is preserved.
  - FULL, pop → ONE. No push is possible in FULL because `in_ready`=0.
- `out_y`/`out_zero` show the head entry while `out_valid`=1. Otherwise they show the idle value: `out_y` = all 0s (all 1s if `ACTIVE_LOW`), `out_zero`=0.
- `xfer_cnt` increments by 1 on every pop. It wraps from 2**CNT_W−1 to 0 with no flag.
- Reset values:
  - Occupancy 0, so `out_valid`=0.
  - `in_ready`=0 during the reset cycle and 1 in the first cycle after.
  - `out_y` = idle value, `out_zero`=0, `xfer_cnt`=0.
- Reset mid-operation discards all buffered words. Handshakes asserted in the reset cycle are ignored and not counted.
- Words are never dropped, duplicated or reordered.

## Timing
- Latency: a word accepted at edge k is presented with `out_valid`=1 from edge k to k+1 (1 cycle) if the buffer was EMPTY. Otherwise it is presented behind the earlier head.
- Throughput: 1 word/cycle while `out_ready` is held high.
- `in_ready` depends only on registered occupancy and `rst`. There is no combinational path from `out_ready` to `in_ready`.
- `out_y`, `out_zero`, `out_valid` and `xfer_cnt` are driven from registers or a registered-select mux. There is no combinational path from any input.

## Structure
- Shared package `decoder_pkg`:
  - N_OUT derivation function.
  - idle-word constant function of `ACTIVE_LOW`.
  - occupancy-state encodings EMPTY/ONE/FULL.
- Sub-module `fifo2_sync`: 2-entry synchronous FIFO with valid/ready on both ends, parameterised on data width (N_OUT+1 bits: word plus zero flag). The top level holds only decode logic, output polarity and the counter.

## Test plan
- Reset, then drive `in_code`=4, `in_en`=1, `out_ready`=1 → next cycle `out_y`=8'b0001_0000, `out_valid`=1, `xfer_cnt`=1 after the pop edge.
- Sweep codes 0..7 back-to-back with `out_ready`=1 → `out_y` shows 0x01,0x02,…,0x80 on consecutive cycles, and `xfer_cnt`=8.
- `in_en`=0 with `in_code`=5 → `out_y`=0x00, `out_zero`=1. With `ACTIVE_LOW`=1, code 2 → `out_y`=8'b1111_1011 and idle = 0xFF.
- Hold `out_ready`=0 and push codes 1, 6, 3 → `in_ready` falls after 2 accepts and code 3 is held upstream. Release `out_ready` → output order is 0x02, 0x40, 0x08.
- Assert `rst` while FULL → next cycle `out_valid`=0, `xfer_cnt`=0, `in_ready`=0 during reset and 1 afterwards. No stale words appear.
- With `CNT_W`=4, perform 17 pops → `xfer_cnt` goes 15 → 0 → 1.
